// File: rtl/sort_result_serializer_pkg.sv
// sort_pkg: default lane count and count width, FSM state type, lane bit-offset helper for packed buses
package sort_pkg;
  localparam int NUM_ELEMENTS = 8;
  localparam int COUNT_WIDTH = $clog2(NUM_ELEMENTS + 1);
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/sort_result_serializer_if.sv
// sort_result_serializer_if: capture inputs (in_done/in_data/in_index/in_count) and valid/ready element stream plus busy/overrun status
interface sort_result_serializer_if #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int IW = 3,
  parameter int CW = $clog2(N + 1)
) ();
  logic          in_done;
  logic [N*W-1:0]  in_data;
  logic [N*IW-1:0] in_index;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic [CW-1:0] out_position;
  logic          out_last;
  logic          busy;
  logic          overrun;
  modport slave (
    input  in_done, in_data, in_index, in_count, out_ready,
    output out_valid, out_data, out_index, out_position, out_last, busy, overrun
  );
  modport master (
    output in_done, in_data, in_index, in_count, out_ready,
    input  out_valid, out_data, out_index, out_position, out_last, busy, overrun
  );
endinterface

// File: rtl/sort_hold_buffer.sv
// sort_hold_buffer: clk/reset, load captures all packed lanes of in_data/in_index, pos selects rd_data/rd_index
module sort_hold_buffer #(
  parameter int N  = 8,
  parameter int W  = 16,
  parameter int IW = 3,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [N*W-1:0]  in_data,
  input  logic [N*IW-1:0] in_index,
  input  logic [AW-1:0]   pos,
  output logic [W-1:0]    rd_data,
  output logic [IW-1:0]   rd_index
);
  import sort_pkg::*;
  logic [W-1:0]  val [N];
  logic [IW-1:0] idx [N];
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        val[i] <= '0;
        idx[i] <= '0;
      end else if (load) begin
        val[i] <= in_data[lane_lo(i, W) +: W];
        idx[i] <= in_index[lane_lo(i, IW) +: IW];
      end
    end
  end
  assign rd_data  = val[pos];
  assign rd_index = idx[pos];
endmodule

// File: rtl/sort_result_serializer.sv
// sort_result_serializer: clk/reset plus bus (slave); captures sorted lanes on in_done rise, streams top-K elements with valid/ready
module sort_result_serializer #(
  parameter int NUM_ELEMENTS  = sort_pkg::NUM_ELEMENTS,
  parameter int NETWORK_WIDTH = 16,
  parameter int INDEX_WIDTH   = 3,
  parameter int COUNT_WIDTH   = $clog2(NUM_ELEMENTS + 1)
) (
  input logic clk,
  input logic reset,
  sort_result_serializer_if.slave bus
);
  import sort_pkg::*;
  localparam int AW = $clog2(NUM_ELEMENTS);
  localparam logic [COUNT_WIDTH-1:0] NE = COUNT_WIDTH'(NUM_ELEMENTS);
  state_t state, state_n;
  logic [COUNT_WIDTH-1:0] pos, pos_n, k, eff_k;
  logic done_q, overrun, ovr_n, trig, hs, last, load;
  assign trig  = bus.in_done & ~done_q;
  assign hs    = bus.out_valid & bus.out_ready;
  assign last  = pos == k - COUNT_WIDTH'(1);
  assign eff_k = (bus.in_count == '0 || bus.in_count > NE) ? NE : bus.in_count;
  always_comb begin
    load    = trig & (state == IDLE | hs & last);
    state_n = load ? STREAM : (hs & last) ? IDLE : state;
    pos_n   = load ? '0 : (hs & ~last) ? pos + COUNT_WIDTH'(1) : pos;
    ovr_n   = overrun | (trig & ~load);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pos     <= '0;
      k       <= '0;
      done_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      pos     <= pos_n;
      done_q  <= bus.in_done;
      overrun <= ovr_n;
      if (load) k <= eff_k;
    end
  end
  sort_hold_buffer #(
    .N (NUM_ELEMENTS),
    .W (NETWORK_WIDTH),
    .IW(INDEX_WIDTH),
    .AW(AW)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .in_data (bus.in_data),
    .in_index(bus.in_index),
    .pos     (pos[AW-1:0]),
    .rd_data (bus.out_data),
    .rd_index(bus.out_index)
  );
  assign bus.out_valid    = state == STREAM;
  assign bus.busy         = state == STREAM;
  assign bus.out_position = pos;
  assign bus.out_last     = (state == STREAM) & last;
  assign bus.overrun      = overrun;
endmodule

// File: tb/tb_sort_result_serializer.sv
// tb_sort_result_serializer: table-driven and directed checks of capture, top-K, backpressure, overrun and reset
module tb_sort_result_serializer;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [3:0] cnt;
    logic [7:0] pat;
    int         k;
  } vec_t;
  vec_t tbl [6];
  sort_result_serializer_if bus ();
  sort_result_serializer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic int exp_val(input int sel, input int i);
    return sel == 1 ? i + 1 : 900 - 100 * i;
  endfunction
  function automatic int exp_idx(input int sel, input int i);
    return sel == 1 ? i : 7 - i;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic set_lanes(input int sel);
    for (int i = 0; i < 8; i++) begin
      bus.in_data[i*16 +: 16] = sel == 2 ? 16'hDEAD ^ 16'(i) : 16'(exp_val(sel, i));
      bus.in_index[i*3 +: 3]  = sel == 2 ? 3'd0 : 3'(exp_idx(sel, i));
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.in_done = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_position", bus.out_position, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_index", bus.out_index, 0);
  endtask
  task automatic start(input int sel, input logic [3:0] cnt);
    check("idle_valid", bus.out_valid, 0);
    set_lanes(sel);
    bus.in_count = cnt;
    bus.in_done = 1'b1;
    @(negedge clk);
    set_lanes(2);
  endtask
  task automatic drain(input int sel, input int k, input logic [7:0] pat, input int first);
    int got = first;
    for (int c = 0; c < 64 && got < k; c++) begin
      bus.out_ready = pat[c % 8];
      check("valid", bus.out_valid, 1);
      check("busy", bus.busy, 1);
      check("data", bus.out_data, exp_val(sel, got));
      check("index", bus.out_index, exp_idx(sel, got));
      check("position", bus.out_position, got);
      check("last", bus.out_last, int'(got == k - 1));
      if (bus.out_ready) got++;
      @(negedge clk);
    end
    check("stream_complete", got, k);
    bus.out_ready = 1'b0;
    check("end_valid", bus.out_valid, 0);
    check("end_busy", bus.busy, 0);
  endtask
  initial begin
    int seen;
    tbl[0] = '{4'd0, 8'hFF, 8};
    tbl[1] = '{4'd0, 8'b1001_1001, 8};
    tbl[2] = '{4'd3, 8'hFF, 3};
    tbl[3] = '{4'd1, 8'hFF, 1};
    tbl[4] = '{4'd9, 8'b0101_0101, 8};
    tbl[5] = '{4'd5, 8'b0011_0110, 5};
    bus.in_count = '0;
    set_lanes(0);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      repeat (r == 0 ? 8 : 1) begin
        check("pre_valid", bus.out_valid, 0);
        @(negedge clk);
      end
      start(0, tbl[r].cnt);
      drain(0, tbl[r].k, tbl[r].pat, 0);
      check("row_overrun", bus.overrun, 0);
    end
    do_reset();
    start(0, 4'd0);
    drain(0, 8, 8'hFF, 0);
    seen = 0;
    bus.out_ready = 1'b1;
    repeat (50) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check("sticky_no_restream", seen, 0);
    check("sticky_overrun", bus.overrun, 0);
    do_reset();
    start(0, 4'd0);
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_position", bus.out_position, 4);
    reset = 1'b1;
    bus.in_done = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_overrun", bus.overrun, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_position", bus.out_position, 0);
    start(1, 4'd0);
    check("restart_data", bus.out_data, 1);
    drain(1, 8, 8'hFF, 0);
    do_reset();
    start(0, 4'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_position", bus.out_position, 2);
    bus.in_done = 1'b0;
    @(negedge clk);
    bus.in_done = 1'b1;
    @(negedge clk);
    check("ovr_set", bus.overrun, 1);
    drain(0, 8, 8'hFF, 4);
    seen = 0;
    bus.out_ready = 1'b1;
    repeat (10) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check("ovr_no_second", seen, 0);
    check("ovr_sticky", bus.overrun, 1);
    do_reset();
    start(0, 4'd3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_done = 1'b0;
    @(negedge clk);
    check("coinc_last", bus.out_last, 1);
    set_lanes(1);
    bus.in_count = 4'd0;
    bus.in_done = 1'b1;
    @(negedge clk);
    set_lanes(2);
    check("coinc_overrun", bus.overrun, 0);
    drain(1, 8, 8'hFF, 0);
    check("coinc_end_overrun", bus.overrun, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
